det_sched: RTL and testbench
============================

DET_SCHED -- requirements
Module: det_sched

Interface
REQ-001 Parameter: FRAME_LEN, 16, bits per frame; legal range 4..255.
REQ-002 Parameter: PATTERN, 4'b1011, 4-bit pattern to detect, MSB received first.
REQ-003 Port: clock  input  1  clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  reset, asynchronous, active-high.
REQ-005 Port: req  input  4  per-requester request; req[i] high means data_i holds a frame.
REQ-006 Port: data_0..data_3  input  FRAME_LEN each  frame words, sent MSB first.
REQ-007 Port: ack  output  4  one-hot grant pulse, one cycle, marks the cycle data is sampled.
REQ-008 Port: busy  output  1  high from ack cycle through done cycle inclusive.
REQ-009 Port: done  output  1  one-cycle pulse, frame result valid.
REQ-010 Port: done_id  output  2  requester index of the finished frame; valid with done.
REQ-011 Port: match_cnt  output  8  overlapping PATTERN matches in the frame; valid with done.
REQ-012 Port: found  output  1  equals (match_cnt != 0); valid with done.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-014 In IDLE with req != 0, the block SHALL select a requester by the arbitration rule.
  - Same cycle: pulse ack[sel].
  - Latch data_sel into the shift register and sel into the ID register.
  - Clear the 4-bit history and the bit/match counters.
  - Next state: SHIFT.
REQ-015 Default arbitration SHALL be round-robin: search starts at last_grant+1 modulo 4; last_grant updates on every ack.
REQ-016 In SHIFT, each cycle SHALL shift one bit, MSB first, into the history register and increment the bit counter.
REQ-017 A match SHALL count when the updated 4-bit history equals PATTERN and at least 4 bits of the current frame have been shifted.
  - Matches overlap.
  - History never spans frames.
REQ-018 After FRAME_LEN shifts, the FSM SHALL enter DONE.
  - done=1; done_id, match_cnt and found driven for that cycle.
  - Next state: IDLE.
REQ-019 done_id, match_cnt and found SHALL hold their values until the next done; done and ack SHALL be 0 outside their pulse cycles.
REQ-020 Timing SHALL be fixed: done asserts exactly FRAME_LEN+1 cycles after ack.
  - Back-to-back frames repeat every FRAME_LEN+2 cycles.
  - The earliest next ack is the cycle after done.
REQ-021 req changes outside IDLE SHALL be ignored; a req dropped before its ack is never granted; data inputs are sampled only in the ack cycle.
REQ-022 At most one ack bit SHALL be high in any cycle.

Reset
REQ-023 Reset SHALL act immediately, including mid-SHIFT; the in-flight frame is discarded with no done.
REQ-024 Reset SHALL force:
  - FSM to IDLE.
  - ack, busy, done, found to 0; done_id to 0; match_cnt to 0.
  - history and counters to 0.
  - last_grant to 3, so requester 0 has first priority.
REQ-025 The first cycle after reset release SHALL be a normal IDLE cycle, able to grant.

Configuration
REQ-026 Macro DET_SCHED_FIXED_PRIO_EN selects the arbitration rule.
  - Defined: fixed priority, lowest index wins; last_grant is unused.
  - Undefined: round-robin per REQ-015.
  - All other behaviour is identical in both builds.

Verification (FRAME_LEN=16, PATTERN=4'b1011)
REQ-027 req=4'b0100, data_2=16'hB000 -> ack=4'b0100 for one cycle; done 17 cycles later with done_id=2, match_cnt=1, found=1.
REQ-028 req[0], data_0=16'hB6C0 (overlapping) -> match_cnt=3; then data_0=16'h0000 -> match_cnt=0, found=0.
REQ-029 Cross-frame check: data_0=16'h0001 then data_1=16'h6000 back-to-back -> both frames match_cnt=0.
REQ-030 req=4'b1111 held -> acks 0,1,2,3,0 at 18-cycle spacing; with DET_SCHED_FIXED_PRIO_EN -> acks 0,0,0.
REQ-031 Reset pulsed 5 cycles into SHIFT with req=4'b0010 held -> busy=0 immediately, no done; ack[1] in the first cycle after release.

Source files
------------

// File: rtl/det_sched.sv
// Frame scheduler: grants one of four requesters, shifts its frame MSB first and counts
// overlapping PATTERN matches. Define DET_SCHED_FIXED_PRIO_EN for fixed-priority arbitration.
module det_sched #(
  parameter int unsigned FRAME_LEN = 16,
  parameter logic [3:0]  PATTERN   = 4'b1011
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [3:0]           req,
  input  logic [FRAME_LEN-1:0] data_0,
  input  logic [FRAME_LEN-1:0] data_1,
  input  logic [FRAME_LEN-1:0] data_2,
  input  logic [FRAME_LEN-1:0] data_3,
  output logic [3:0]           ack,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           done_id,
  output logic [7:0]           match_cnt,
  output logic                 found
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e               state_q;
  logic [FRAME_LEN-1:0] shift_q;
  logic [3:0]           hist_q;
  logic [7:0]           bit_cnt_q;
  logic [7:0]           cnt_q;
  logic [1:0]           id_q;
  logic [1:0]           done_id_q;
  logic [7:0]           match_cnt_q;
  logic                 found_q;

  logic [1:0]           sel;
  logic                 grant;
  logic [FRAME_LEN-1:0] data_sel;
  logic [3:0]           hist_nxt;
  logic                 hit;
  logic [7:0]           cnt_nxt;

`ifdef DET_SCHED_FIXED_PRIO_EN
  always_comb begin
    sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) sel = 2'(i);
    end
  end
`else
  logic [1:0] last_grant_q;
  logic [1:0] rr_idx;

  // Walk from farthest to nearest so the first requester after last_grant wins.
  always_comb begin
    sel    = 2'd0;
    rr_idx = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      rr_idx = last_grant_q + 2'(k);
      if (req[rr_idx]) sel = rr_idx;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant_q <= 2'd3;
    end else if (grant) begin
      last_grant_q <= sel;
    end
  end
`endif

  always_comb begin
    case (sel)
      2'd0:    data_sel = data_0;
      2'd1:    data_sel = data_1;
      2'd2:    data_sel = data_2;
      default: data_sel = data_3;
    endcase
  end

  assign grant    = (state_q == StIdle) && (req != 4'b0000) && !reset;
  assign hist_nxt = {hist_q[2:0], shift_q[FRAME_LEN-1]};
  // bit_cnt_q counts bits shifted before this one, so >= 3 means at least 4 with this bit.
  assign hit      = (hist_nxt == PATTERN) && (bit_cnt_q >= 8'd3);
  assign cnt_nxt  = cnt_q + {7'd0, hit};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      hist_q      <= 4'd0;
      bit_cnt_q   <= 8'd0;
      cnt_q       <= 8'd0;
      id_q        <= 2'd0;
      done_id_q   <= 2'd0;
      match_cnt_q <= 8'd0;
      found_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant) begin
            shift_q   <= data_sel;
            id_q      <= sel;
            hist_q    <= 4'd0;
            bit_cnt_q <= 8'd0;
            cnt_q     <= 8'd0;
            state_q   <= StShift;
          end
        end
        StShift: begin
          shift_q   <= shift_q << 1;
          hist_q    <= hist_nxt;
          bit_cnt_q <= bit_cnt_q + 8'd1;
          cnt_q     <= cnt_nxt;
          if (bit_cnt_q == 8'(FRAME_LEN - 1)) begin
            done_id_q   <= id_q;
            match_cnt_q <= cnt_nxt;
            found_q     <= (cnt_nxt != 8'd0);
            state_q     <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign ack       = grant ? 4'(4'b0001 << sel) : 4'b0000;
  assign busy      = !reset && ((state_q != StIdle) || grant);
  assign done      = (state_q == StDone);
  assign done_id   = done_id_q;
  assign match_cnt = match_cnt_q;
  assign found     = found_q;

endmodule

// File: tb/tb_det_sched.sv
// Bench for det_sched: directed scenarios plus random traffic against a frame-level model.
module tb_det_sched;

  localparam int unsigned FL  = 16;
  localparam logic [3:0]  PAT = 4'b1011;

  logic          clock;
  logic          reset;
  logic [3:0]    req;
  logic [FL-1:0] data_0, data_1, data_2, data_3;
  logic [3:0]    ack;
  logic          busy, done, found;
  logic [1:0]    done_id;
  logic [7:0]    match_cnt;

  int n_cmp = 0;
  int n_err = 0;

  det_sched #(.FRAME_LEN(FL), .PATTERN(PAT)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .data_0    (data_0),
    .data_1    (data_1),
    .data_2    (data_2),
    .data_3    (data_3),
    .ack       (ack),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .match_cnt (match_cnt),
    .found     (found)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: slide a 4-bit window over the frame and count equal windows.
  function automatic int count_matches(input logic [FL-1:0] d);
    int n = 0;
    logic [FL-1:0] w;
    for (int i = 0; i <= int'(FL) - 4; i++) begin
      w = d >> (int'(FL) - 4 - i);
      if (w[3:0] == PAT) n++;
    end
    return n;
  endfunction

  function automatic int pick(input logic [3:0] r, input int last);
`ifdef DET_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= 4; k++) if (r[(last + k) % 4]) return (last + k) % 4;
`endif
    return 0;
  endfunction

  function automatic logic [FL-1:0] data_of(input int id);
    case (id)
      0:       return data_0;
      1:       return data_1;
      2:       return data_2;
      default: return data_3;
    endcase
  endfunction

  // Cycle-level expectations: phase = cycles since ack, -1 when idle.
  int            phase = -1;
  int            m_last = 3;
  int            m_id = 0;
  logic [FL-1:0] m_data;
  int            e_id = 0, e_cnt = 0;
  logic          e_found = 1'b0, e_busy, e_done;
  logic [3:0]    e_ack;

  always @(negedge clock) begin
    e_ack  = 4'b0000;
    e_done = 1'b0;
    if (reset) begin
      phase   = -1;
      m_last  = 3;
      e_id    = 0;
      e_cnt   = 0;
      e_found = 1'b0;
      e_busy  = 1'b0;
    end else begin
      if (phase < 0 && req != 4'b0000) begin
        m_id   = pick(req, m_last);
        m_last = m_id;
        m_data = data_of(m_id);
        e_ack  = 4'(1 << m_id);
        phase  = 0;
      end
      e_busy = (phase >= 0);
      if (phase == int'(FL) + 1) begin
        e_done  = 1'b1;
        e_id    = m_id;
        e_cnt   = count_matches(m_data);
        e_found = (e_cnt != 0);
      end
    end
    chk("ack", 32'(ack), 32'(e_ack));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    chk("done_id", 32'(done_id), 32'(e_id));
    chk("match_cnt", 32'(match_cnt), 32'(e_cnt));
    chk("found", 32'(found), 32'(e_found));
    if (!reset) begin
      if (phase == int'(FL) + 1) phase = -1;
      else if (phase >= 0) phase++;
    end
  end

  task automatic wait_done(output int cyc);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!done && n < 40);
    if (!done) chk("done_timeout", 32'd0, 32'd1);
    cyc = n;
  endtask

  task automatic frame(input logic [3:0] r, input logic [FL-1:0] d0, input logic [FL-1:0] d1,
                       input logic [FL-1:0] d2, input logic [FL-1:0] d3, input int id,
                       input int cnt);
    int c;
    @(posedge clock); #1;
    req = r; data_0 = d0; data_1 = d1; data_2 = d2; data_3 = d3;
    @(negedge clock);
    chk("frame_ack", 32'(ack), 32'(1) << id);
    @(posedge clock); #1;
    req = 4'b0000;
    wait_done(c);
    chk("frame_latency", 32'(c), FL + 1);
    chk("frame_id", 32'(done_id), 32'(id));
    chk("frame_cnt", 32'(match_cnt), 32'(cnt));
    chk("frame_found", 32'(found), 32'(cnt != 0));
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    req   = 4'b0000;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  function automatic int oh2id(input logic [3:0] a);
    for (int i = 0; i < 4; i++) if (a[i]) return i;
    return -1;
  endfunction

  initial begin
    int n, c;
    reset = 1'b1;
    req = 4'b0000;
    data_0 = '0; data_1 = '0; data_2 = '0; data_3 = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    frame(4'b0100, 16'h0000, 16'h0000, 16'hB000, 16'h0000, 2, 1);
    frame(4'b0001, 16'hB6C0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 3);
    frame(4'b0001, 16'h0000, 16'hB6C0, 16'hB6C0, 16'hB6C0, 0, 0);
    frame(4'b0001, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    frame(4'b0010, 16'h0000, 16'h6000, 16'h0000, 16'h0000, 1, 0);

    // All four requesting continuously.
    do_reset();
    @(posedge clock); #1;
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      do begin
        @(negedge clock);
        n++;
      end while (ack == 4'b0000 && n < 40);
`ifdef DET_SCHED_FIXED_PRIO_EN
      chk("hold_grant_id", 32'(oh2id(ack)), 32'd0);
`else
      chk("hold_grant_id", 32'(oh2id(ack)), 32'(g % 4));
`endif
      if (g > 0) chk("hold_spacing", 32'(n), FL + 2);
      @(posedge clock); #1;
    end
    req = 4'b0000;

    // Reset five cycles into a shift.
    do_reset();
    @(posedge clock); #1;
    req = 4'b0010;
    @(negedge clock);
    chk("mid_reset_ack", 32'(ack), 32'b0010);
    repeat (5) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("mid_reset_busy", 32'(busy), 32'd0);
    chk("mid_reset_done", 32'(done), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk("post_reset_ack", 32'(ack), 32'b0010);
    @(posedge clock); #1;
    req = 4'b0000;
    wait_done(c);
    chk("post_reset_latency", 32'(c), FL + 1);

    // Random traffic, occasional resets.
    for (int i = 0; i < 2500; i++) begin
      @(posedge clock); #1;
      reset  = ($urandom_range(0, 299) == 0);
      req    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      data_0 = FL'($urandom);
      data_1 = FL'($urandom);
      data_2 = ($urandom_range(0, 1) == 0) ? 16'hB6C0 : FL'($urandom);
      data_3 = FL'($urandom);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    req   = 4'b0000;
    repeat (25) @(posedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
